// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: minimum divisor,
// run-state encoding, divisor clamp and half-period helpers.
package clk_div_pkg;

  // Smallest divisor ever applied; 0 and 1 are promoted to this.
  localparam int unsigned MIN_DIV = 2;

  // Divider run state: idle (output parked low) or running periods.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Promote illegal divisors (0, 1) to MIN_DIV; others pass unchanged.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    logic [31:0] r;
    if (v < 32'(MIN_DIV)) begin
      r = 32'(MIN_DIV);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // ceil(n/2), computed one bit wider so the maximum divisor cannot overflow.
  function automatic logic [31:0] half_period(input logic [31:0] n);
    logic [32:0] sum;
    sum = {1'b0, n} + 33'd1;
    return sum[32:1];
  endfunction

endpackage

// File: rtl/clk_divider_prog_if.sv
// Control/status bundle of the programmable clock divider.
// master = the controlling logic, slave = the divider itself.
interface clk_divider_prog_if #(
  parameter int DIV_W = 8
);

  logic             en;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             out_clk;
  logic             tick;
  logic             div_pending;
  logic [DIV_W-1:0] cur_div;

  modport master (
    output en, div_load, div_val,
    input  out_clk, tick, div_pending, cur_div
  );

  modport slave (
    input  en, div_load, div_val,
    output out_clk, tick, div_pending, cur_div
  );

endinterface

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider. Produces a registered divided
// clock (high ceil(N/2) cycles, low the rest) and a one-cycle tick in the
// cycle the divided clock rises. Divisor changes and run/idle transitions
// only happen at period boundaries so no runt pulse can ever appear.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic               clk,
  input  logic               rst,
  clk_divider_prog_if.slave  bus
);

  localparam logic [DIV_W-1:0] ONE_C     = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO_C    = DIV_W'(0);
  localparam logic [DIV_W-1:0] DEFAULT_C = DIV_W'(DIV_DEFAULT);

  run_state_e       state_r;
  run_state_e       state_nxt_s;

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;
  logic [DIV_W-1:0] cur_div_r;
  logic [DIV_W-1:0] cur_div_nxt_s;
  logic [DIV_W-1:0] pend_div_r;
  logic [DIV_W-1:0] pend_div_nxt_s;
  logic             div_pending_r;
  logic             div_pending_nxt_s;
  logic             out_clk_r;
  logic             out_clk_nxt_s;
  logic             tick_r;
  logic             tick_nxt_s;

  logic [DIV_W-1:0] clamp_val_s;
  logic [DIV_W:0]   half_s;
  logic [DIV_W:0]   cnt_inc_s;
  logic             boundary_s;

  // Requested divisor with 0/1 promoted, and the high-phase length of the
  // divisor in effect (one extra bit so 2^DIV_W-1 does not overflow).
  assign clamp_val_s = DIV_W'(clamp_div(32'(bus.div_val)));
  assign half_s      = (DIV_W+1)'(half_period(32'(cur_div_r)));
  assign cnt_inc_s   = {1'b0, cnt_r} + {{DIV_W{1'b0}}, 1'b1};

  // Period boundary: always while idle, otherwise on the last count.
  always_comb begin
    boundary_s = 1'b0;
    if (state_r == ST_IDLE) begin
      boundary_s = 1'b1;
    end else if (cnt_r == (cur_div_r - ONE_C)) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = 1'b0;
    end
  end

  // Run-state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next run state: en is only honoured at a boundary.
  always_comb begin
    state_nxt_s = state_r;
    if (boundary_s) begin
      if (bus.en) begin
        state_nxt_s = ST_RUN;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next counter, output, and divisor-update values.
  always_comb begin
    cnt_nxt_s         = cnt_r;
    out_clk_nxt_s     = out_clk_r;
    tick_nxt_s        = 1'b0;
    cur_div_nxt_s     = cur_div_r;
    pend_div_nxt_s    = pend_div_r;
    div_pending_nxt_s = div_pending_r;

    if (boundary_s) begin
      // New period (or idle) starts; a load in this very cycle wins over
      // any pending divisor and applies to the period starting now.
      cnt_nxt_s     = ZERO_C;
      out_clk_nxt_s = bus.en;
      tick_nxt_s    = bus.en;
      if (bus.div_load) begin
        cur_div_nxt_s     = clamp_val_s;
        div_pending_nxt_s = 1'b0;
      end else if (div_pending_r) begin
        cur_div_nxt_s     = pend_div_r;
        div_pending_nxt_s = 1'b0;
      end else begin
        cur_div_nxt_s     = cur_div_r;
        div_pending_nxt_s = div_pending_r;
      end
    end else begin
      // Mid-period: advance, keep the divisor stable, park any load.
      cnt_nxt_s     = cnt_inc_s[DIV_W-1:0];
      out_clk_nxt_s = (cnt_inc_s < half_s);
      tick_nxt_s    = 1'b0;
      if (bus.div_load) begin
        pend_div_nxt_s    = clamp_val_s;
        div_pending_nxt_s = 1'b1;
      end else begin
        pend_div_nxt_s    = pend_div_r;
        div_pending_nxt_s = div_pending_r;
      end
    end
  end

  // Datapath and output registers; reset discards any pending divisor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r         <= ZERO_C;
      out_clk_r     <= 1'b0;
      tick_r        <= 1'b0;
      cur_div_r     <= DEFAULT_C;
      pend_div_r    <= ZERO_C;
      div_pending_r <= 1'b0;
    end else begin
      cnt_r         <= cnt_nxt_s;
      out_clk_r     <= out_clk_nxt_s;
      tick_r        <= tick_nxt_s;
      cur_div_r     <= cur_div_nxt_s;
      pend_div_r    <= pend_div_nxt_s;
      div_pending_r <= div_pending_nxt_s;
    end
  end

  assign bus.out_clk     = out_clk_r;
  assign bus.tick        = tick_r;
  assign bus.div_pending = div_pending_r;
  assign bus.cur_div     = cur_div_r;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog. Inputs change and
// outputs are observed on the falling clock edge.
module tb_clk_divider_prog;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  clk_divider_prog_if #(.DIV_W(8)) bus ();

  clk_divider_prog #(.DIV_W(8), .DIV_DEFAULT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hold reset two cycles, then release with the given run request.
  task automatic do_reset(input logic start_en);
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = 8'd0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    bus.en = start_en;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    total++; if (bus.out_clk !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", bus.out_clk); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    total++; if (bus.div_pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", bus.div_pending); end
    total++; if (bus.cur_div !== 8'd4) begin bad++; $display("FAIL reset_div got=%0d exp=4", bus.cur_div); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.out_clk !== 1'b0 || bus.tick !== 1'b0) begin bad++; $display("FAIL idle_low k=%0d got=%b/%b exp=0/0", k, bus.out_clk, bus.tick); end
    end
    bus.en = 1'b1;
    @(negedge clk);
    total++; if (bus.out_clk !== 1'b1 || bus.tick !== 1'b1) begin bad++; $display("FAIL first_rise got=%b/%b exp=1/1", bus.out_clk, bus.tick); end
  endtask

  task automatic test_default;
    logic eo, et;
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      eo = ((k % 4) < 2);
      et = ((k % 4) == 0);
      total++; if (bus.out_clk !== eo) begin bad++; $display("FAIL div4_out k=%0d got=%b exp=%b", k, bus.out_clk, eo); end
      total++; if (bus.tick !== et) begin bad++; $display("FAIL div4_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
      total++; if (bus.cur_div !== 8'd4) begin bad++; $display("FAIL div4_div k=%0d got=%0d exp=4", k, bus.cur_div); end
    end
  endtask

  task automatic test_load_mid;
    logic eo, et, ep;
    logic [7:0] ed;
    int j;
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      j  = k - 4;
      eo = (k < 4) ? ((k % 4) < 2) : ((j % 5) < 3);
      et = (k < 4) ? (k == 0) : ((j % 5) == 0);
      ep = (k >= 1) && (k <= 3);
      ed = (k < 4) ? 8'd4 : 8'd5;
      total++; if (bus.out_clk !== eo) begin bad++; $display("FAIL load5_out k=%0d got=%b exp=%b", k, bus.out_clk, eo); end
      total++; if (bus.tick !== et) begin bad++; $display("FAIL load5_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
      total++; if (bus.div_pending !== ep) begin bad++; $display("FAIL load5_pend k=%0d got=%b exp=%b", k, bus.div_pending, ep); end
      total++; if (bus.cur_div !== ed) begin bad++; $display("FAIL load5_div k=%0d got=%0d exp=%0d", k, bus.cur_div, ed); end
      bus.div_load = (k == 0);
      bus.div_val  = 8'd5;
    end
  endtask

  task automatic test_clamp_last_wins;
    logic eo, et, ep;
    logic [7:0] ed;
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      eo = (k < 4) ? ((k % 4) < 2) : ((k % 2) == 0);
      et = (k < 4) ? (k == 0) : ((k % 2) == 0);
      ep = (k >= 1) && (k <= 3);
      ed = (k < 4) ? 8'd4 : 8'd2;
      total++; if (bus.out_clk !== eo) begin bad++; $display("FAIL clamp_out k=%0d got=%b exp=%b", k, bus.out_clk, eo); end
      total++; if (bus.tick !== et) begin bad++; $display("FAIL clamp_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
      total++; if (bus.div_pending !== ep) begin bad++; $display("FAIL clamp_pend k=%0d got=%b exp=%b", k, bus.div_pending, ep); end
      total++; if (bus.cur_div !== ed) begin bad++; $display("FAIL clamp_div k=%0d got=%0d exp=%0d", k, bus.cur_div, ed); end
      bus.div_load = (k <= 1);
      bus.div_val  = (k == 0) ? 8'd0 : 8'd1;
    end
  endtask

  task automatic test_load_at_boundary;
    logic eo, et;
    logic [7:0] ed;
    int j;
    do_reset(1'b1);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      j  = k - 4;
      eo = (k < 4) ? ((k % 4) < 2) : ((j % 3) < 2);
      et = (k < 4) ? (k == 0) : ((j % 3) == 0);
      ed = (k < 4) ? 8'd4 : 8'd3;
      total++; if (bus.out_clk !== eo) begin bad++; $display("FAIL bnd3_out k=%0d got=%b exp=%b", k, bus.out_clk, eo); end
      total++; if (bus.tick !== et) begin bad++; $display("FAIL bnd3_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
      total++; if (bus.div_pending !== 1'b0) begin bad++; $display("FAIL bnd3_pend k=%0d got=%b exp=0", k, bus.div_pending); end
      total++; if (bus.cur_div !== ed) begin bad++; $display("FAIL bnd3_div k=%0d got=%0d exp=%0d", k, bus.cur_div, ed); end
      bus.div_load = (k == 3);
      bus.div_val  = 8'd3;
    end
  endtask

  task automatic test_en_drop;
    logic eo, et;
    logic [7:0] ed;
    int j;
    do_reset(1'b1);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      j = k - 4;
      if (k < 4) begin
        eo = ((k % 4) < 2); et = (k == 0);
      end else if (k < 10) begin
        eo = (j < 3); et = (j == 0);
      end else if (k < 15) begin
        eo = 1'b0; et = 1'b0;
      end else begin
        eo = 1'b1; et = (k == 15);
      end
      ed = (k < 4) ? 8'd4 : 8'd6;
      total++; if (bus.out_clk !== eo) begin bad++; $display("FAIL endrop_out k=%0d got=%b exp=%b", k, bus.out_clk, eo); end
      total++; if (bus.tick !== et) begin bad++; $display("FAIL endrop_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
      total++; if (bus.cur_div !== ed) begin bad++; $display("FAIL endrop_div k=%0d got=%0d exp=%0d", k, bus.cur_div, ed); end
      bus.div_load = (k == 3);
      bus.div_val  = 8'd6;
      if (k == 5) bus.en = 1'b0;
      if (k == 14) bus.en = 1'b1;
    end
  endtask

  task automatic test_rst_mid;
    logic eo, et;
    do_reset(1'b1);
    @(negedge clk);
    bus.div_load = 1'b1;
    bus.div_val  = 8'd7;
    @(negedge clk);
    bus.div_load = 1'b0;
    total++; if (bus.div_pending !== 1'b1) begin bad++; $display("FAIL rstmid_pre_pend got=%b exp=1", bus.div_pending); end
    total++; if (bus.out_clk !== 1'b1) begin bad++; $display("FAIL rstmid_pre_out got=%b exp=1", bus.out_clk); end
    rst = 1'b0;
    #1;
    total++; if (bus.out_clk !== 1'b0 || bus.tick !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b/%b exp=0/0", bus.out_clk, bus.tick); end
    total++; if (bus.div_pending !== 1'b0) begin bad++; $display("FAIL rstmid_pend got=%b exp=0", bus.div_pending); end
    total++; if (bus.cur_div !== 8'd4) begin bad++; $display("FAIL rstmid_div got=%0d exp=4", bus.cur_div); end
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      eo = ((k % 4) < 2);
      et = ((k % 4) == 0);
      total++; if (bus.out_clk !== eo || bus.tick !== et) begin bad++; $display("FAIL rstmid_run k=%0d got=%b/%b exp=%b/%b", k, bus.out_clk, bus.tick, eo, et); end
      total++; if (bus.cur_div !== 8'd4 || bus.div_pending !== 1'b0) begin bad++; $display("FAIL rstmid_discard k=%0d got=%0d/%b exp=4/0", k, bus.cur_div, bus.div_pending); end
    end
  endtask

  task automatic test_max_div;
    logic eo, et;
    int highs;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.div_load = 1'b1;
    bus.div_val  = 8'd255;
    highs = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      bus.div_load = 1'b0;
      eo = (j < 128) || (j == 255);
      et = (j == 0) || (j == 255);
      if (j < 255 && bus.out_clk === 1'b1) highs++;
      total++; if (bus.out_clk !== eo || bus.tick !== et) begin bad++; $display("FAIL max_run j=%0d got=%b/%b exp=%b/%b", j, bus.out_clk, bus.tick, eo, et); end
      if (j == 0) begin
        total++; if (bus.cur_div !== 8'd255) begin bad++; $display("FAIL max_div got=%0d exp=255", bus.cur_div); end
      end
    end
    total++; if (highs !== 128) begin bad++; $display("FAIL max_high_count got=%0d exp=128", highs); end
  endtask

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = 8'd0;
    test_reset();
    test_default();
    test_load_mid();
    test_clamp_last_wins();
    test_load_at_boundary();
    test_en_drop();
    test_rst_mid();
    test_max_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
